// File: rtl/tx.sv
// USB-PD protocol-layer transmitter: sends the buffered header with the current MessageID, waits for GoodCRC, retries, raises alerts.
// Latency: transmit_write to phy_tx_req 2 cycles; GoodCRC to tx_success 1 cycle; alert pulses last 1 cycle.
// Backpressure: phy_tx_req held until phy_tx_done; transmit_write ignored while busy; rx_busy at check time discards the request.
//
// Ports:
//   clk, hard_reset            - clock and synchronous active-high reset
//   TRANSMIT, transmit_write   - TRANSMIT register value ([2:0] SOP type, [5:4] retries) and its write strobe
//   TX_BUF_HEADER_BYTE_0/1     - header bytes [7:0] / [15:8]
//   rx_busy                    - receiver holds an unread message or is mid-reception
//   phy_tx_done                - PHY finished the frame
//   phy_rx_goodcrc(_msgid)     - GoodCRC pulse and the MessageID it carries
//   phy_tx_req/_sop/_header    - frame request to the PHY (header bits [11:9] carry msg_id)
//   tx_success/failed/discarded- one-cycle alert pulses
//   tx_busy, msg_id            - not-idle flag and current MessageID counter
//
// Optional feature macro: TX_MSGID_CHECK_EN (GoodCRC accepted only when its MessageID matches msg_id).

module tx #(
    parameter int CRC_TIMEOUT = 16,
    parameter int TIMER_W     = 8
) (
    input  logic        clk,
    input  logic        hard_reset,
    input  logic [7:0]  TRANSMIT,
    input  logic        transmit_write,
    input  logic [7:0]  TX_BUF_HEADER_BYTE_0,
    input  logic [7:0]  TX_BUF_HEADER_BYTE_1,
    input  logic        rx_busy,
    input  logic        phy_tx_done,
    input  logic        phy_rx_goodcrc,
    input  logic [2:0]  phy_rx_goodcrc_msgid,
    output logic        phy_tx_req,
    output logic [2:0]  phy_tx_sop,
    output logic [15:0] phy_tx_header,
    output logic        tx_success,
    output logic        tx_failed,
    output logic        tx_discarded,
    output logic        tx_busy,
    output logic [2:0]  msg_id
);

    localparam logic [TIMER_W-1:0] TIMER_LAST      = TIMER_W'(CRC_TIMEOUT - 1);
    localparam logic [2:0]         SOP_HARD_RESET  = 3'b101;
    localparam logic [2:0]         SOP_CABLE_RESET = 3'b110;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_SEND,
        S_WAIT_CRC,
        S_RETRY,
        S_SUCCESS,
        S_FAILED,
        S_DISCARD
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [2:0]           sop_q;
    logic [1:0]           retry_max_q;
    logic [1:0]           retries_done_q;
    logic [15:0]          hdr_q;
    logic [TIMER_W-1:0]   timer_q;
    logic                 sop_reserved;
    logic                 sop_is_reset;
    logic                 goodcrc_ok;
    logic                 unused_bits;

    assign sop_reserved = (sop_q == 3'b011) || (sop_q == 3'b100) || (sop_q == 3'b111);
    // Hard/Cable Reset signalling is never acknowledged by GoodCRC.
    assign sop_is_reset = (sop_q == SOP_HARD_RESET) || (sop_q == SOP_CABLE_RESET);

`ifdef TX_MSGID_CHECK_EN
    assign goodcrc_ok  = phy_rx_goodcrc && (phy_rx_goodcrc_msgid == msg_id);
    assign unused_bits = ^{TRANSMIT[7:6], TRANSMIT[3], hdr_q[11:9]};
`else
    assign goodcrc_ok  = phy_rx_goodcrc;
    assign unused_bits = ^{TRANSMIT[7:6], TRANSMIT[3], hdr_q[11:9], phy_rx_goodcrc_msgid};
`endif

    always_ff @(posedge clk) begin
        if (hard_reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        phy_tx_req    = 1'b0;
        phy_tx_sop    = 3'b000;
        phy_tx_header = 16'h0000;
        tx_success    = 1'b0;
        tx_failed     = 1'b0;
        tx_discarded  = 1'b0;
        tx_busy       = (state_q != S_IDLE);
        case (state_q)
            S_IDLE: begin
                if (transmit_write) state_d = S_CHECK;
            end
            S_CHECK: begin
                if (rx_busy)           state_d = S_DISCARD;
                else if (sop_reserved) state_d = S_FAILED;
                else                   state_d = S_SEND;
            end
            S_SEND: begin
                phy_tx_req    = 1'b1;
                phy_tx_sop    = sop_q;
                phy_tx_header = {hdr_q[15:12], msg_id, hdr_q[8:0]};
                if (phy_tx_done) state_d = sop_is_reset ? S_SUCCESS : S_WAIT_CRC;
            end
            S_WAIT_CRC: begin
                // GoodCRC takes priority over a coincident timeout.
                if (goodcrc_ok)                state_d = S_SUCCESS;
                else if (timer_q == TIMER_LAST) state_d = S_RETRY;
            end
            S_RETRY: begin
                state_d = (retries_done_q < retry_max_q) ? S_SEND : S_FAILED;
            end
            S_SUCCESS: begin
                tx_success = 1'b1;
                state_d    = S_IDLE;
            end
            S_FAILED: begin
                tx_failed = 1'b1;
                state_d   = S_IDLE;
            end
            S_DISCARD: begin
                tx_discarded = 1'b1;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (hard_reset) begin
            sop_q          <= 3'b000;
            retry_max_q    <= 2'b00;
            retries_done_q <= 2'b00;
            hdr_q          <= 16'h0000;
            timer_q        <= '0;
            msg_id         <= 3'b000;
        end else begin
            if ((state_q == S_IDLE) && transmit_write) begin
                sop_q          <= TRANSMIT[2:0];
                retry_max_q    <= TRANSMIT[5:4];
                retries_done_q <= 2'b00;
                hdr_q          <= {TX_BUF_HEADER_BYTE_1, TX_BUF_HEADER_BYTE_0};
            end
            if ((state_q == S_SEND) && phy_tx_done) begin
                timer_q <= '0;
            end
            if (state_q == S_WAIT_CRC) begin
                timer_q <= timer_q + TIMER_W'(1);
            end
            if ((state_q == S_RETRY) && (retries_done_q < retry_max_q)) begin
                retries_done_q <= retries_done_q + 2'd1;
            end
            // MessageID advances only once the message is confirmed delivered.
            if (state_q == S_SUCCESS) begin
                case (sop_q)
                    3'b000, 3'b001, 3'b010: msg_id <= msg_id + 3'd1;
                    SOP_HARD_RESET:         msg_id <= 3'd0;
                    default:                ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tx.sv
// Directed bench for tx: a cycle-timeline model of the transmit protocol sets the required outputs
// for every cycle, a negedge process compares all DUT outputs to them, and literal pins anchor
// key values (MessageID sequence, header contents, pulse timing, request counts).

module tb_tx;
    localparam int CRC_TIMEOUT = 16;
    localparam int PHY_CYC     = 3;   // cycles the PHY holds a frame before phy_tx_done

    localparam int P_MSG      = 0;
    localparam int P_BUSY     = 1;
    localparam int P_HDR      = 2;
    localparam int P_HDR_ID   = 3;
    localparam int P_RISES    = 4;
    localparam int P_SUCC     = 5;
    localparam int P_FAIL_CYC = 6;
    localparam int P_DISC_CYC = 7;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        hard_reset;
    logic [7:0]  TRANSMIT;
    logic        transmit_write;
    logic [7:0]  TX_BUF_HEADER_BYTE_0;
    logic [7:0]  TX_BUF_HEADER_BYTE_1;
    logic        rx_busy;
    logic        phy_tx_done;
    logic        phy_rx_goodcrc;
    logic [2:0]  phy_rx_goodcrc_msgid;
    logic        phy_tx_req;
    logic [2:0]  phy_tx_sop;
    logic [15:0] phy_tx_header;
    logic        tx_success;
    logic        tx_failed;
    logic        tx_discarded;
    logic        tx_busy;
    logic [2:0]  msg_id;

    tx #(.CRC_TIMEOUT(CRC_TIMEOUT), .TIMER_W(8)) dut (
        .clk                  (clk),
        .hard_reset           (hard_reset),
        .TRANSMIT             (TRANSMIT),
        .transmit_write       (transmit_write),
        .TX_BUF_HEADER_BYTE_0 (TX_BUF_HEADER_BYTE_0),
        .TX_BUF_HEADER_BYTE_1 (TX_BUF_HEADER_BYTE_1),
        .rx_busy              (rx_busy),
        .phy_tx_done          (phy_tx_done),
        .phy_rx_goodcrc       (phy_rx_goodcrc),
        .phy_rx_goodcrc_msgid (phy_rx_goodcrc_msgid),
        .phy_tx_req           (phy_tx_req),
        .phy_tx_sop           (phy_tx_sop),
        .phy_tx_header        (phy_tx_header),
        .tx_success           (tx_success),
        .tx_failed            (tx_failed),
        .tx_discarded         (tx_discarded),
        .tx_busy              (tx_busy),
        .msg_id               (msg_id)
    );

    // Required outputs for the current cycle (owned by the stimulus process).
    logic        exp_req, exp_succ, exp_fail, exp_disc, exp_busy;
    logic [2:0]  exp_sop, exp_msg;
    logic [15:0] exp_hdr;
    logic [2:0]  m_msg;
    int          cyc;
    bit          chk_en;
    int          done_cyc, w_cyc;

    bit          lit_en;
    string       lit_name;
    int          lit_sel, lit_val;

    // Owned by the compare process.
    int          n_checks = 0;
    int          n_fail = 0;
    int          req_rises = 0;
    int          succ_cnt = 0;
    int          last_fail_cyc = -1;
    int          last_disc_cyc = -1;
    logic [15:0] last_req_hdr = 16'h0;
    logic        req_q = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%0h, required 0x%0h", name, cyc, act, req);
        end
    endtask

    always @(negedge clk) begin
        int act;
        if (chk_en) begin
            chk("phy_tx_req",    32'(phy_tx_req),    32'(exp_req));
            chk("phy_tx_sop",    32'(phy_tx_sop),    32'(exp_sop));
            chk("phy_tx_header", 32'(phy_tx_header), 32'(exp_hdr));
            chk("tx_success",    32'(tx_success),    32'(exp_succ));
            chk("tx_failed",     32'(tx_failed),     32'(exp_fail));
            chk("tx_discarded",  32'(tx_discarded),  32'(exp_disc));
            chk("tx_busy",       32'(tx_busy),       32'(exp_busy));
            chk("msg_id",        32'(msg_id),        32'(exp_msg));
            chk("single_alert",  32'((32'(tx_success) + 32'(tx_failed) + 32'(tx_discarded)) > 1), 32'd0);
            if (phy_tx_req) last_req_hdr = phy_tx_header;
            if (phy_tx_req && !req_q) req_rises++;
            req_q = phy_tx_req;
            if (tx_success)   succ_cnt++;
            if (tx_failed)    last_fail_cyc = cyc;
            if (tx_discarded) last_disc_cyc = cyc;
        end
        if (lit_en) begin
            case (lit_sel)
                P_MSG:      act = int'(msg_id);
                P_BUSY:     act = int'(tx_busy);
                P_HDR:      act = int'(last_req_hdr);
                P_HDR_ID:   act = int'(last_req_hdr[11:9]);
                P_RISES:    act = req_rises;
                P_SUCC:     act = succ_cnt;
                P_FAIL_CYC: act = last_fail_cyc;
                default:    act = last_disc_cyc;
            endcase
            chk(lit_name, 32'(act), 32'(lit_val));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        lit_en = 1'b0;
    endtask

    task automatic pin(input string name, input int sel, input int val);
        lit_name = name;
        lit_sel  = sel;
        lit_val  = val;
        lit_en   = 1'b1;
    endtask

    task automatic expect_state(input logic busy);
        exp_req  = 1'b0; exp_sop  = 3'b000; exp_hdr  = 16'h0;
        exp_succ = 1'b0; exp_fail = 1'b0;   exp_disc = 1'b0;
        exp_busy = busy; exp_msg  = m_msg;
    endtask

    // Header as transmitted: bits [11:9] carry the MessageID.
    function automatic logic [15:0] with_id(input logic [15:0] h, input logic [2:0] id);
        return (h & 16'hF1FF) | (16'(id) << 9);
    endfunction

    // One complete TRANSMIT request. d1/d2: GoodCRC arrives d cycles after the phy_tx_done
    // cycle of every attempt (-1 = none), carrying id1/id2.
    task automatic do_tx(input logic [7:0] tr, input logic [15:0] hdr, input logic rxb,
                         input int d1, input logic [2:0] id1, input int d2, input logic [2:0] id2);
        logic [2:0] sop;
        int         attempts;
        bit         ok;
        bit         acc;
        sop      = tr[2:0];
        attempts = int'(tr[5:4]) + 1;
        ok       = 1'b0;
        expect_state(1'b0);
        transmit_write = 1'b1; TRANSMIT = tr; rx_busy = rxb;
        TX_BUF_HEADER_BYTE_0 = hdr[7:0]; TX_BUF_HEADER_BYTE_1 = hdr[15:8];
        w_cyc = cyc;
        tick();
        transmit_write = 1'b0;
        expect_state(1'b1);                 // request being examined
        tick();
        rx_busy = 1'b0;
        if (rxb) begin
            expect_state(1'b1); exp_disc = 1'b1; tick();
        end else if (sop == 3'b011 || sop == 3'b100 || sop == 3'b111) begin
            expect_state(1'b1); exp_fail = 1'b1; tick();
        end else begin
            for (int a = 0; a < attempts && !ok; a++) begin
                for (int k = 0; k < PHY_CYC; k++) begin
                    expect_state(1'b1);
                    exp_req = 1'b1; exp_sop = sop; exp_hdr = with_id(hdr, m_msg);
                    phy_tx_done = (k == PHY_CYC - 1);
                    if (phy_tx_done) done_cyc = cyc;
                    tick();
                end
                phy_tx_done = 1'b0;
                if (sop == 3'b101 || sop == 3'b110) begin
                    ok = 1'b1;
                end else begin
                    for (int n = 1; n <= CRC_TIMEOUT && !ok; n++) begin
                        expect_state(1'b1);
                        phy_rx_goodcrc       = (n == d1) || (n == d2);
                        phy_rx_goodcrc_msgid = (n == d1) ? id1 : id2;
`ifdef TX_MSGID_CHECK_EN
                        acc = phy_rx_goodcrc && (phy_rx_goodcrc_msgid == m_msg);
`else
                        acc = phy_rx_goodcrc;
`endif
                        tick();
                        phy_rx_goodcrc = 1'b0;
                        if (acc) ok = 1'b1;
                    end
                    if (!ok) begin
                        expect_state(1'b1);     // retry decision cycle
                        tick();
                    end
                end
            end
            expect_state(1'b1);
            if (ok) exp_succ = 1'b1;
            else    exp_fail = 1'b1;
            tick();
            if (ok) begin
                case (sop)
                    3'b000, 3'b001, 3'b010: m_msg = m_msg + 3'd1;
                    3'b101:                 m_msg = 3'd0;
                    default:                ;
                endcase
            end
        end
        expect_state(1'b0);
    endtask

    initial begin
        int base;
        int msg_tbl [8];
        msg_tbl = '{1, 2, 3, 4, 5, 6, 7, 0};
        hard_reset = 1'b1; transmit_write = 1'b0; TRANSMIT = 8'h00;
        TX_BUF_HEADER_BYTE_0 = 8'h00; TX_BUF_HEADER_BYTE_1 = 8'h00;
        rx_busy = 1'b0; phy_tx_done = 1'b0; phy_rx_goodcrc = 1'b0; phy_rx_goodcrc_msgid = 3'd0;
        lit_en = 1'b0; lit_name = ""; lit_sel = 0; lit_val = 0;
        chk_en = 1'b0; cyc = 0; m_msg = 3'd0; done_cyc = 0; w_cyc = 0;
        expect_state(1'b0);
        tick();
        chk_en = 1'b1;
        pin("reset_msg_id", P_MSG, 0);
        tick();
        hard_reset = 1'b0;
        pin("reset_busy", P_BUSY, 0);
        tick();

        // SOP, 1 retry allowed, GoodCRC 3 cycles after done.
        base = succ_cnt;
        do_tx(8'h10, 16'h1161, 1'b0, 3, 3'd0, -1, 3'd0);
        pin("t1_msg_id", P_MSG, 1);            tick();
        pin("t1_header", P_HDR, 32'h1161);     tick();
        pin("t1_one_success", P_SUCC, base + 1); tick();

        // Two retries, no GoodCRC: three attempts, then failure.
        base = req_rises;
        do_tx(8'h20, 16'h5A3C, 1'b0, -1, 3'd0, -1, 3'd0);
        pin("t2_three_requests", P_RISES, base + 3); tick();
        // 16 CRC-wait cycles, one retry decision cycle, then the pulse: 18 cycles after the done cycle.
        pin("t2_fail_timing", P_FAIL_CYC, done_cyc + 18); tick();
        pin("t2_msg_id", P_MSG, 1);            tick();

        // Receiver busy at check time: discarded, no request.
        base = req_rises;
        do_tx(8'h00, 16'h1161, 1'b1, -1, 3'd0, -1, 3'd0);
        pin("t3_no_request", P_RISES, base);   tick();
        pin("t3_discard_timing", P_DISC_CYC, w_cyc + 2); tick();

        // Bring msg_id to 2, then a GoodCRC with ID 3 followed by one with ID 2.
        do_tx(8'h10, 16'h1161, 1'b0, 2, 3'd1, -1, 3'd0);
        pin("t4_msg_id_pre", P_MSG, 2);        tick();
        base = succ_cnt;
        do_tx(8'h00, 16'h2345, 1'b0, 2, 3'd3, 5, 3'd2);
        pin("t4_msg_id_post", P_MSG, 3);       tick();
        pin("t4_one_success", P_SUCC, base + 1); tick();

        // Reset, then eight SOP successes: msg_id 1..7, 0.
        hard_reset = 1'b1;
        tick();
        hard_reset = 1'b0; m_msg = 3'd0; expect_state(1'b0);
        pin("t5_msg_after_reset", P_MSG, 0);   tick();
        for (int i = 0; i < 8; i++) begin
            do_tx(8'h00, 16'hFFFF, 1'b0, 1, 3'(i), -1, 3'd0);
            pin("t5_msg_seq", P_MSG, msg_tbl[i]); tick();
            pin("t5_hdr_id", P_HDR_ID, i);     tick();
        end

        // Hard Reset signalling clears msg_id without waiting for GoodCRC.
        do_tx(8'h00, 16'h1161, 1'b0, 1, 3'd0, -1, 3'd0);
        pin("t6_msg_pre", P_MSG, 1);           tick();
        base = succ_cnt;
        do_tx(8'h05, 16'h0000, 1'b0, -1, 3'd0, -1, 3'd0);
        pin("t6_msg_cleared", P_MSG, 0);       tick();
        pin("t6_hr_success", P_SUCC, base + 1); tick();

        // Five SOP' successes, Cable Reset leaves msg_id, reserved SOP fails at once.
        for (int i = 0; i < 5; i++) do_tx(8'h01, 16'h0A00, 1'b0, 2, m_msg, -1, 3'd0);
        do_tx(8'h06, 16'h0000, 1'b0, -1, 3'd0, -1, 3'd0);
        pin("t7_cable_msg", P_MSG, 5);         tick();
        do_tx(8'h03, 16'h1161, 1'b0, -1, 3'd0, -1, 3'd0);
        pin("t7_reserved_fail", P_FAIL_CYC, w_cyc + 2); tick();

        // hard_reset while waiting for GoodCRC with msg_id 5.
        base = succ_cnt;
        expect_state(1'b0);
        transmit_write = 1'b1; TRANSMIT = 8'h00;
        TX_BUF_HEADER_BYTE_0 = 8'h61; TX_BUF_HEADER_BYTE_1 = 8'h11;
        tick();
        transmit_write = 1'b0; expect_state(1'b1); tick();
        expect_state(1'b1); exp_req = 1'b1; exp_hdr = with_id(16'h1161, m_msg);
        phy_tx_done = 1'b1; tick();
        phy_tx_done = 1'b0; expect_state(1'b1); tick();
        expect_state(1'b1); hard_reset = 1'b1; tick();
        hard_reset = 1'b0; m_msg = 3'd0; expect_state(1'b0);
        pin("t8_busy_cleared", P_BUSY, 0);     tick();
        pin("t8_msg_cleared", P_MSG, 0);       tick();
        phy_rx_goodcrc = 1'b1; phy_rx_goodcrc_msgid = 3'd5; tick();
        phy_rx_goodcrc = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        pin("t8_no_alert", P_SUCC, base);      tick();

        chk_en = 1'b0;
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
